// File: rtl/not_i2s_decoder_mc.sv
// Serial decoder: SYNC byte followed by CHANNELS samples of WIDTH bits, MSB first on rising sck.
// Define NSI2S_WATCHDOG_EN to add the loss-of-lock watchdog (TIMEOUT clk cycles).
module not_i2s_decoder_mc #(
   parameter int         WIDTH    = 16,
   parameter int         CHANNELS = 2,
   parameter logic [7:0] SYNC     = 8'hAA,
   parameter int         TIMEOUT  = 1048576
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sck,
   input  logic                      sd,
   output logic [CHANNELS*WIDTH-1:0] samples,
   output logic                      sample_valid,
   output logic                      locked
);
   localparam int N  = CHANNELS * WIDTH;
   localparam int SW = 8 + N - 1;

   logic          sck_m, scks, sck_prev;
   logic          sd_m, sds;
   logic [SW-1:0] shreg;
   logic [SW:0]   cand;
   logic          edge_det;
   logic          hit;
   logic          wd_fire;
   logic [N-1:0]  frame_ord;

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_m    <= 1'b0;
         scks     <= 1'b0;
         sck_prev <= 1'b0;
         sd_m     <= 1'b0;
         sds      <= 1'b0;
      end else begin
         sck_m    <= sck;
         scks     <= sck_m;
         sck_prev <= scks;
         sd_m     <= sd;
         sds      <= sd_m;
      end
   end

   assign edge_det = scks & ~sck_prev;
   assign cand     = {shreg, sds};
   assign hit      = edge_det && (cand[SW -: 8] == SYNC);

   // Earliest-received channel sits highest in the candidate; channel 0 goes to the low lane.
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign frame_ord[k*WIDTH +: WIDTH] = cand[N-1-k*WIDTH -: WIDTH];
   end

   // Clearing on a match keeps an overlapping frame from re-triggering early.
   always_ff @(posedge clk) begin
      if (rst)
         shreg <= '0;
      else if (edge_det)
         shreg <= hit ? '0 : cand[SW-1:0];
   end

`ifdef NSI2S_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wd_cnt;

   assign wd_fire = !hit && (wd_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || hit)
         wd_cnt <= '0;
      else if (wd_cnt != CW'(TIMEOUT))
         wd_cnt <= wd_cnt + CW'(1);
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         samples      <= '0;
         sample_valid <= 1'b0;
         locked       <= 1'b0;
      end else begin
         sample_valid <= hit;
         if (hit) begin
            samples <= frame_ord;
            locked  <= 1'b1;
         end else if (wd_fire) begin
            samples <= '0;
            locked  <= 1'b0;
         end
      end
   end
endmodule

// File: doc/not_i2s_decoder_mc.md
NOT_I2S_DECODER_MC -- requirements
Module: not_i2s_decoder_mc

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WIDTH, 16, bits per channel sample (range 8..32).
- CHANNELS, 2, samples per frame (range 1..8).
- SYNC, 8'hAA, frame sync byte.
- TIMEOUT, 1048576, clk cycles without a frame before loss of lock (used only with NSI2S_WATCHDOG_EN).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock. The block has one clock.
- rst, in, 1, synchronous active-high reset.
- sck, in, 1, asynchronous serial bit clock.
- sd, in, 1, asynchronous serial data.
- samples, out, CHANNELS*WIDTH, last good frame; channel k at [k*WIDTH +: WIDTH].
- sample_valid, out, 1, one-clk pulse when samples updates with a new frame.
- locked, out, 1, high while frames are being received.

Function
REQ-003 sck and sd shall each pass through a 2-flop synchroniser clocked by clk; the block shall use only the synchronised copies scks and sds.
REQ-004 A rising sck edge shall be detected when scks is 1 and its previous-cycle value is 0; all shifting happens only on that clk cycle.
REQ-005 Frame format on sd, MSB first, sampled on rising sck: 8-bit SYNC, then channel 0 (WIDTH bits), then channel 1, up to channel CHANNELS-1. No ws or gap bits are used.
REQ-006 The shift register S shall be 8+N-1 bits, where N=CHANNELS*WIDTH. On each detected edge, the candidate C={S,sds} (8+N bits) shall be formed.
REQ-007 If C[8+N-1 -: 8]==SYNC: samples<=C[N-1:0] with channel 0 taken from the earliest-received bits; sample_valid<=1 for exactly one clk cycle; S<=0. Otherwise S<=C[8+N-2:0].
REQ-008 Clearing S after a match shall prevent a partly overlapping frame from matching until 8+N new bits have been shifted in.
REQ-009 Latency: samples and sample_valid shall update on the clk edge on which the edge is detected. This is the 3rd clk rising edge after the edge that first samples sck high at the pin.
REQ-010 samples shall hold its value between frames. sample_valid shall be 0 on every cycle other than the update cycle.
REQ-011 locked shall go 1 on the same cycle as the first sample_valid.
REQ-012 sd changes with no rising sck edge shall have no effect on the block.

Reset
REQ-013 With rst high at a clk edge, the following shall be cleared: synchronisers, the previous-sck flop, S, samples (all 0), sample_valid (0), locked (0) and the watchdog counter.
REQ-014 Reset asserted in the middle of a frame shall discard the partial frame. The first valid frame after reset requires a complete SYNC+N bit sequence.

Configuration
REQ-015 Macro NSI2S_WATCHDOG_EN defined:
- a saturating counter of ceil(log2(TIMEOUT+1)) bits shall count clk cycles and clear on each sample_valid;
- when the counter reaches TIMEOUT, locked<=0 and samples<=0 on that cycle;
- a later valid frame shall restore normal operation.
REQ-016 Macro NSI2S_WATCHDOG_EN undefined: no counter is instantiated, TIMEOUT is ignored, and locked stays 1 from the first frame until rst.

Verification
REQ-017 Defaults: send AA,1234,ABCD at 1/8 clk rate -> single pulse; samples[15:0]=16'h1234, samples[31:16]=16'hABCD; locked=1.
REQ-018 Latency: measure clk edges from the pin-level sck rise of the last data bit to sample_valid -> exactly 3.
REQ-019 Back-to-back frames AA,0001,0002 then AA,FFFF,8000 -> two pulses 8+32 sck edges apart; final samples={16'h8000,16'hFFFF}.
REQ-020 Stray bits: data containing AA in its payload (AA,AAAA,AAAA) -> exactly one pulse with samples={16'hAAAA,16'hAAAA}; no extra pulse before the next full frame.
REQ-021 WIDTH=24, CHANNELS=4: frame AA,000001,000002,000003,000004 -> samples[23:0]=1, [95:72]=4, one pulse.
REQ-022 With NSI2S_WATCHDOG_EN and TIMEOUT=100:
- one frame then stop sck -> 100 clk after the pulse, locked=0 and samples=0;
- rst asserted mid-frame -> no pulse for that frame, all outputs 0.
